// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks every input vector of a small combinational function block in
// ascending order, records the function output for each vector, and compares
// the recorded truth table against an expected table latched at start.
// Results (captured table, mismatch count, first failing vector, pass flag)
// stay valid after the sweep until the next start.

module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2**N_IN-1:0]   expected_i,
    input  logic                 f_in_i,
    output logic [N_IN-1:0]      vec_out_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2**N_IN-1:0]   table_out_o,
    output logic [N_IN:0]        mismatch_cnt_o,
    output logic [N_IN-1:0]      first_fail_o,
    output logic                 pass_o
);

    // Number of vectors in one sweep and the widths derived from it.
    localparam int NumVec = 2**N_IN;
    localparam int CntW   = N_IN + 1;

    // The settle counter runs 0 .. SETTLE-1, so it needs at least one bit
    // even when SETTLE is 1.
    localparam int SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SetW-1:0] LastSettle = SetW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LastVec    = N_IN'(NumVec - 1);

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                state_q,        state_d;
    logic [N_IN-1:0]       vecIdx_q,       vecIdx_d;
    logic [SetW-1:0]       settleCnt_q,    settleCnt_d;
    logic [NumVec-1:0]     expLatched_q,   expLatched_d;
    logic [NumVec-1:0]     captured_q,     captured_d;
    logic [CntW-1:0]       mismatchCnt_q,  mismatchCnt_d;
    logic [N_IN-1:0]       firstFail_q,    firstFail_d;
    logic                  pass_q,         pass_d;

    // A vector fails when the function output disagrees with the expected
    // bit for the vector currently applied.
    logic sampleMismatch;
    assign sampleMismatch = (f_in_i != expLatched_q[vecIdx_q]);

    // Next-state logic: walks IDLE -> (APPLY -> SAMPLE) x NumVec -> DONE -> IDLE.
    always_comb begin
        state_d       = state_q;
        vecIdx_d      = vecIdx_q;
        settleCnt_d   = settleCnt_q;
        expLatched_d  = expLatched_q;
        captured_d    = captured_q;
        mismatchCnt_d = mismatchCnt_q;
        firstFail_d   = firstFail_q;
        pass_d        = pass_q;

        case (state_q)
            IDLE: begin
                // Between sweeps the driven vector parks at 0 and the
                // results of the previous sweep are held.
                vecIdx_d    = '0;
                settleCnt_d = '0;
                if (start_i) begin
                    state_d       = APPLY;
                    expLatched_d  = expected_i;
                    captured_d    = '0;
                    mismatchCnt_d = '0;
                    firstFail_d   = '0;
                    pass_d        = 1'b0;
                end
            end

            APPLY: begin
                // Hold the vector for SETTLE cycles so the function block
                // output has settled before it is sampled.
                if (settleCnt_q == LastSettle) begin
                    settleCnt_d = '0;
                    state_d     = SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q + SetW'(1);
                end
            end

            SAMPLE: begin
                captured_d[vecIdx_q] = f_in_i;
                if (sampleMismatch) begin
                    mismatchCnt_d = mismatchCnt_q + CntW'(1);
                    if (mismatchCnt_q == '0) begin
                        firstFail_d = vecIdx_q;
                    end
                end
                // The index stops at the last vector rather than wrapping.
                if (vecIdx_q == LastVec) begin
                    state_d = DONE;
                    pass_d  = (mismatchCnt_d == '0);
                end else begin
                    vecIdx_d = vecIdx_q + N_IN'(1);
                    state_d  = APPLY;
                end
            end

            DONE: begin
                // Single-cycle completion state; start is not looked at here,
                // so a held start begins the next sweep from IDLE.
                state_d  = IDLE;
                vecIdx_d = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            vecIdx_q      <= '0;
            settleCnt_q   <= '0;
            expLatched_q  <= '0;
            captured_q    <= '0;
            mismatchCnt_q <= '0;
            firstFail_q   <= '0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vecIdx_q      <= vecIdx_d;
            settleCnt_q   <= settleCnt_d;
            expLatched_q  <= expLatched_d;
            captured_q    <= captured_d;
            mismatchCnt_q <= mismatchCnt_d;
            firstFail_q   <= firstFail_d;
            pass_q        <= pass_d;
        end
    end

    // Status flags decode straight from the registered state, so they are
    // glitch-free and fall to 0 with the asynchronous reset.
    assign busy_o         = (state_q == APPLY) || (state_q == SAMPLE);
    assign done_o         = (state_q == DONE);
    assign vec_out_o      = vecIdx_q;
    assign table_out_o    = captured_q;
    assign mismatch_cnt_o = mismatchCnt_q;
    assign first_fail_o   = firstFail_q;
    assign pass_o         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Directed and randomized sweeps of truth_table_sweeper with SETTLE=1 and
// SETTLE=3 instances, checked against a table-level reference model.

module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start1, start3;
    logic [15:0] exp1, exp3;
    logic [15:0] ftab1, ftab3;
    logic        f1, f3;

    logic [3:0]  vec1, vec3;
    logic        busy1, busy3, done1, done3, pass1, pass3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  mis1, mis3;
    logic [3:0]  first1, first3;

    // The function block under control is simply a lookup into a table the
    // bench chooses per sweep.
    assign f1 = ftab1[vec1];
    assign f3 = ftab3[vec3];

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start1),
        .expected_i     (exp1),
        .f_in_i         (f1),
        .vec_out_o      (vec1),
        .busy_o         (busy1),
        .done_o         (done1),
        .table_out_o    (tbl1),
        .mismatch_cnt_o (mis1),
        .first_fail_o   (first1),
        .pass_o         (pass1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start3),
        .expected_i     (exp3),
        .f_in_i         (f3),
        .vec_out_o      (vec3),
        .busy_o         (busy3),
        .done_o         (done3),
        .table_out_o    (tbl3),
        .mismatch_cnt_o (mis3),
        .first_fail_o   (first3),
        .pass_o         (pass3)
    );

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    // Outputs of whichever instance the current step is exercising.
    logic [3:0]  vecS, firstS;
    logic        busyS, doneS, passS;
    logic [15:0] tblS;
    logic [4:0]  misS;
    assign vecS   = (sel == 1) ? vec3   : vec1;
    assign busyS  = (sel == 1) ? busy3  : busy1;
    assign doneS  = (sel == 1) ? done3  : done1;
    assign passS  = (sel == 1) ? pass3  : pass1;
    assign tblS   = (sel == 1) ? tbl3   : tbl1;
    assign misS   = (sel == 1) ? mis3   : mis1;
    assign firstS = (sel == 1) ? first3 : first1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference truth tables computed directly from the Boolean functions.
    function automatic logic [15:0] xorTable();
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            t[i] = v[3] ^ v[2] ^ v[1] ^ v[0];
        end
        return t;
    endfunction

    function automatic logic [15:0] andTable();
        logic [15:0] t;
        logic [3:0]  v;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            t[i] = v[3] & v[2];
        end
        return t;
    endfunction

    function automatic int lowestSetBit(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            if (d[i]) return i;
        end
        return 0;
    endfunction

    task automatic driveInputs(input int which, input logic s, input logic [15:0] e);
        if (which == 1) begin
            start3 = s;
            exp3   = e;
        end else begin
            start1 = s;
            exp1   = e;
        end
    endtask

    // Present a one-cycle start pulse; returns #1 after the start edge.
    task automatic applyStimulus(input int which, input logic [15:0] ftab,
                                 input logic [15:0] expv);
        @(negedge clk);
        sel = which;
        if (which == 1) ftab3 = ftab;
        else            ftab1 = ftab;
        driveInputs(which, 1'b1, expv);
        @(posedge clk);
        #1;
        driveInputs(which, 1'b0, expv);
    endtask

    // Full sweep with timing and result checks against the table model.
    task automatic runSweep(input string name, input int which, input int settle,
                            input logic [15:0] ftab, input logic [15:0] expv,
                            input bit disturb);
        int          n;
        int          period;
        logic [15:0] diff;
        period = settle + 1;
        diff   = ftab ^ expv;
        applyStimulus(which, ftab, expv);
        n = 0;
        checkOutput({name, " busy@start"}, 32'(busyS), 32'd1);
        checkOutput({name, " vec@start"}, 32'(vecS), 32'd0);
        while (!doneS && n < 40 * period) begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 5)  driveInputs(which, 1'b1, ~expv);
            if (disturb && n == 6)  driveInputs(which, 1'b0, ~expv ^ 16'h00F0);
            if (!doneS) begin
                checkOutput({name, " vec"}, 32'(vecS), 32'(n / period));
                checkOutput({name, " busy"}, 32'(busyS), 32'd1);
            end
        end
        checkOutput({name, " done seen"}, 32'(doneS), 32'd1);
        checkOutput({name, " done latency"}, 32'(n), 32'(16 * period));
        checkOutput({name, " busy@done"}, 32'(busyS), 32'd0);
        checkOutput({name, " table"}, 32'(tblS), 32'(ftab));
        checkOutput({name, " mismatch_cnt"}, 32'(misS), 32'($countones(diff)));
        checkOutput({name, " first_fail"}, 32'(firstS), 32'(lowestSetBit(diff)));
        checkOutput({name, " pass"}, 32'(passS), 32'(diff == 16'h0));
        @(posedge clk);
        #1;
        checkOutput({name, " done pulse width"}, 32'(doneS), 32'd0);
        checkOutput({name, " idle busy"}, 32'(busyS), 32'd0);
        checkOutput({name, " idle vec"}, 32'(vecS), 32'd0);
        checkOutput({name, " held table"}, 32'(tblS), 32'(ftab));
        checkOutput({name, " held pass"}, 32'(passS), 32'(diff == 16'h0));
    endtask

    initial begin
        int          n;
        bit          doneSeen;
        logic [15:0] rf, re;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        exp1   = 16'h0;
        exp3   = 16'h0;
        ftab1  = 16'h0;
        ftab3  = 16'h0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset vec", 32'(vec1), 32'd0);
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset done", 32'(done1), 32'd0);
        checkOutput("reset table", 32'(tbl1), 32'd0);
        checkOutput("reset mismatch", 32'(mis1), 32'd0);
        checkOutput("reset first", 32'(first1), 32'd0);
        checkOutput("reset pass", 32'(pass1), 32'd0);
        checkOutput("reset busy3", 32'(busy3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed sweeps");
        runSweep("xor ok", 0, 1, xorTable(), 16'h6996, 1'b0);
        runSweep("xor one bad", 0, 1, xorTable(), 16'h6997, 1'b0);
        runSweep("and zero exp", 0, 1, andTable(), 16'h0000, 1'b0);

        $display("[TB] reset mid-sweep");
        applyStimulus(0, xorTable(), 16'h6996);
        n = 0;
        while (vec1 != 4'd7 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reached vec 7", 32'(vec1), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst vec", 32'(vec1), 32'd0);
        checkOutput("async rst busy", 32'(busy1), 32'd0);
        checkOutput("async rst table", 32'(tbl1), 32'd0);
        checkOutput("async rst mismatch", 32'(mis1), 32'd0);
        checkOutput("async rst pass", 32'(pass1), 32'd0);
        doneSeen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done1) doneSeen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) doneSeen = 1'b1;
        end
        checkOutput("no done after reset", 32'(doneSeen), 32'd0);
        runSweep("after reset", 0, 1, xorTable(), 16'h6996, 1'b0);

        $display("[TB] start and expected changed mid-sweep");
        runSweep("disturbed", 0, 1, xorTable(), 16'h6996, 1'b1);

        $display("[TB] randomized sweeps");
        for (int r = 0; r < 4; r++) begin
            rf = 16'($urandom);
            re = rf ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            runSweep("random near", 0, 1, rf, re, 1'b0);
        end
        rf = 16'($urandom);
        re = 16'($urandom);
        runSweep("random any", 0, 1, rf, re, 1'b0);

        $display("[TB] SETTLE=3 instance");
        runSweep("settle3 xor", 1, 3, xorTable(), 16'h6996, 1'b0);
        rf = 16'($urandom);
        re = rf ^ 16'($urandom_range(1, 65535));
        runSweep("settle3 random", 1, 3, rf, re, 1'b0);

        $display("[TB] start held high");
        @(negedge clk);
        sel   = 0;
        ftab1 = xorTable();
        driveInputs(0, 1'b1, 16'h6996);
        @(posedge clk);
        #1;
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("held start latency", 32'(n), 32'd32);
        checkOutput("held start pass", 32'(pass1), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("held start idle busy", 32'(busy1), 32'd0);
        checkOutput("held start idle done", 32'(done1), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held start restart busy", 32'(busy1), 32'd1);
        checkOutput("held start restart vec", 32'(vec1), 32'd0);
        driveInputs(0, 1'b0, 16'h6996);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
